// File: rtl/key_expansion_ctrl_if.sv
// rtl/key_expansion_ctrl_if.sv - key load and round-key read bundle for key_expansion_ctrl
interface key_expansion_ctrl_if;
    logic [127:0] i_Key;
    logic         i_KeyValid;
    logic         o_KeyReady;
    logic         o_Busy;
    logic         o_KeysValid;
    logic [3:0]   i_RdRound;
    logic [127:0] o_RdKey;

    modport master (
        output i_Key, i_KeyValid, i_RdRound,
        input  o_KeyReady, o_Busy, o_KeysValid, o_RdKey
    );

    modport slave (
        input  i_Key, i_KeyValid, i_RdRound,
        output o_KeyReady, o_Busy, o_KeysValid, o_RdKey
    );
endinterface

// File: rtl/key_expansion_ctrl.sv
// rtl/key_expansion_ctrl.sv - sequential AES-128 key schedule, one round key per cycle, 11-entry store
// Optional KEYEXP_ZEROIZE_EN adds i_Zeroize, which clears the store and returns to IDLE.
module key_expansion_ctrl (
    input  logic i_Clk,
    input  logic i_Rst_n,
`ifdef KEYEXP_ZEROIZE_EN
    input  logic i_Zeroize,
`endif
    key_expansion_ctrl_if.slave kif
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // RotWord, SubWord, then Rcon folded into the top byte
    function automatic logic [31:0] g_function(input logic [31:0] w, input logic [3:0] r);
        logic [31:0] rot;
        rot = {w[23:0], w[31:24]};
        return {sub_byte(rot[31:24]) ^ rcon(r), sub_byte(rot[23:16]),
                sub_byte(rot[15:8]), sub_byte(rot[7:0])};
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] rk_q [0:10];
    logic         key_ready_q, busy_q, keys_valid_q;

    logic         accept;
    logic         rk_we;
    logic         rk_clear;
    logic [3:0]   rk_widx;
    logic [127:0] rk_wdata;
    logic [3:0]   prev_idx;
    logic [127:0] prev_rk;
    logic [127:0] next_rk;
    logic [127:0] rd_key;
    logic [31:0]  g_word;
    logic [31:0]  w0n, w1n, w2n, w3n;

    assign prev_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;

    always_comb begin
        prev_rk = '0;
        for (int i = 0; i < 11; i++) begin
            if (prev_idx == 4'(i)) prev_rk = rk_q[i];
        end
    end

    assign g_word  = g_function(prev_rk[31:0], round_q);
    assign w0n     = prev_rk[127:96] ^ g_word;
    assign w1n     = prev_rk[95:64]  ^ w0n;
    assign w2n     = prev_rk[63:32]  ^ w1n;
    assign w3n     = prev_rk[31:0]   ^ w2n;
    assign next_rk = {w0n, w1n, w2n, w3n};

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        rk_we    = 1'b0;
        rk_clear = 1'b0;
        rk_widx  = round_q;
        rk_wdata = next_rk;
        accept   = kif.i_KeyValid & key_ready_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    rk_we    = 1'b1;
                    rk_widx  = 4'd0;
                    rk_wdata = kif.i_Key;
                    round_d  = 4'd1;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                rk_we = 1'b1;
                if (round_q == 4'd10) begin
                    round_d = 4'd0;
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                round_d = 4'd0;
                state_d = IDLE;
            end
        endcase
`ifdef KEYEXP_ZEROIZE_EN
        // Zeroize outranks any key accept in the same cycle
        if (i_Zeroize) begin
            accept   = 1'b0;
            rk_we    = 1'b0;
            rk_clear = 1'b1;
            round_d  = 4'd0;
            state_d  = IDLE;
        end
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q      <= IDLE;
            round_q      <= 4'd0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            key_ready_q  <= (state_d != EXPAND);
            busy_q       <= (state_d == EXPAND);
            keys_valid_q <= (state_d == DONE);
        end
    end

    always_ff @(posedge i_Clk) begin
        for (int i = 0; i < 11; i++) begin
            if (!i_Rst_n || rk_clear) begin
                rk_q[i] <= '0;
            end else if (rk_we && (rk_widx == 4'(i))) begin
                rk_q[i] <= rk_wdata;
            end
        end
    end

    // Indices 11..15 fall through to zero
    always_comb begin
        rd_key = '0;
        for (int i = 0; i < 11; i++) begin
            if (kif.i_RdRound == 4'(i)) rd_key = rk_q[i];
        end
    end

    assign kif.o_RdKey     = rd_key;
    assign kif.o_KeyReady  = key_ready_q;
    assign kif.o_Busy      = busy_q;
    assign kif.o_KeysValid = keys_valid_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// tb/tb_key_expansion_ctrl.sv - self-checking bench for key_expansion_ctrl (KEYEXP_ZEROIZE_EN aware)
module tb_key_expansion_ctrl;

    logic clk;
    logic rst_n;
`ifdef KEYEXP_ZEROIZE_EN
    logic zeroize;
`endif

    key_expansion_ctrl_if kif ();

    key_expansion_ctrl dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
`ifdef KEYEXP_ZEROIZE_EN
        .i_Zeroize (zeroize),
`endif
        .kif       (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] mrk [11];
    vec_t         vecs [6];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                            ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-oriented schedule w[0..43]
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input int idx, output logic [127:0] v);
        kif.i_RdRound = 4'(idx);
        #1;
        v = kif.o_RdKey;
    endtask

    task automatic check_all(input string name, input logic zero);
        logic [127:0] v;
        for (int i = 0; i < 11; i++) begin
            read_rk(i, v);
            chk($sformatf("%s_rk%0d", name, i), v, zero ? 128'h0 : mrk[i]);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        int n;
        n = 0;
        while (!kif.o_KeyReady && n < 40) begin
            tick();
            n++;
        end
        chk1("ready_wait_bound", n < 40, 1'b1);
        kif.i_Key      = k;
        kif.i_KeyValid = 1'b1;
        tick();
        kif.i_KeyValid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!kif.o_KeysValid && n < 40) begin
            tick();
            n++;
        end
        chk1("keys_valid_wait_bound", n < 40, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] v;
        logic [127:0] key_a;
        logic [127:0] key_b;
        logic [127:0] rk10_a;

        vecs[0] = '{FIPS_KEY,   4'd0,  FIPS_KEY};
        vecs[1] = '{FIPS_KEY,   4'd1,  FIPS_RK1};
        vecs[2] = '{FIPS_KEY,   4'd10, FIPS_RK10};
        vecs[3] = '{128'h0,     4'd1,  ZERO_RK1};
        vecs[4] = '{128'h0,     4'd10, ZERO_RK10};
        vecs[5] = '{FIPS_KEY,   4'd13, 128'h0};

        build_sbox();
        rst_n          = 1'b0;
        kif.i_Key      = '0;
        kif.i_KeyValid = 1'b0;
        kif.i_RdRound  = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
        zeroize        = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk1("reset_ready", kif.o_KeyReady, 1'b1);
        chk1("reset_busy", kif.o_Busy, 1'b0);
        chk1("reset_keys_valid", kif.o_KeysValid, 1'b0);
        check_all("reset", 1'b1);

        for (int i = 0; i < 6; i++) begin
            load_key(vecs[i].key);
            wait_valid();
            read_rk(int'(vecs[i].idx), v);
            chk($sformatf("vec%0d_idx%0d", i, vecs[i].idx), v, vecs[i].exp);
        end

        // Cycle-accurate FIPS expansion: RK[r] lands after edge T+r
        model_expand(FIPS_KEY);
        load_key(FIPS_KEY);
        chk1("fips_ready_after_accept", kif.o_KeyReady, 1'b0);
        chk1("fips_busy_after_accept", kif.o_Busy, 1'b1);
        chk1("fips_kv_after_accept", kif.o_KeysValid, 1'b0);
        read_rk(0, v);
        chk("fips_rk0_after_accept", v, FIPS_KEY);
        for (int r = 1; r <= 10; r++) begin
            kif.i_RdRound = 4'(r);
            tick();
            chk($sformatf("fips_rk%0d_at_T%0d", r, r), kif.o_RdKey, mrk[r]);
            chk1($sformatf("fips_kv_at_T%0d", r), kif.o_KeysValid, r == 10);
            chk1($sformatf("fips_busy_at_T%0d", r), kif.o_Busy, r != 10);
            chk1($sformatf("fips_ready_at_T%0d", r), kif.o_KeyReady, r == 10);
        end
        for (int r = 11; r < 16; r++) begin
            read_rk(r, v);
            chk($sformatf("oor_idx%0d", r), v, 128'h0);
        end

        // Second key offered throughout EXPAND is taken on the first DONE cycle
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key_a);
        rk10_a = mrk[10];
        kif.i_Key      = key_a;
        kif.i_KeyValid = 1'b1;
        tick();
        kif.i_Key      = key_b;
        kif.i_RdRound  = 4'd10;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk1($sformatf("hs_ready_T%0d", k), kif.o_KeyReady, k == 10);
            chk1($sformatf("hs_kv_T%0d", k), kif.o_KeysValid, k == 10);
        end
        chk("hs_rk10_first_key", kif.o_RdKey, rk10_a);
        tick();
        kif.i_KeyValid = 1'b0;
        chk1("hs_kv_drop", kif.o_KeysValid, 1'b0);
        chk1("hs_busy_rekey", kif.o_Busy, 1'b1);
        read_rk(0, v);
        chk("hs_rk0_second_key", v, key_b);
        model_expand(key_b);
        kif.i_RdRound = 4'd10;
        for (int k = 1; k <= 10; k++) tick();
        chk1("hs_kv_second", kif.o_KeysValid, 1'b1);
        chk("hs_rk10_second_key", kif.o_RdKey, mrk[10]);

        // Reset arriving mid-EXPAND
        load_key(FIPS_KEY);
        for (int k = 1; k <= 5; k++) tick();
        rst_n = 1'b0;
        tick();
        chk1("midrst_ready", kif.o_KeyReady, 1'b1);
        chk1("midrst_busy", kif.o_Busy, 1'b0);
        chk1("midrst_kv", kif.o_KeysValid, 1'b0);
        check_all("midrst", 1'b1);
        rst_n = 1'b1;
        tick();

`ifdef KEYEXP_ZEROIZE_EN
        load_key(FIPS_KEY);
        tick();
        tick();
        zeroize        = 1'b1;
        kif.i_Key      = 128'h0;
        kif.i_KeyValid = 1'b1;
        tick();
        zeroize        = 1'b0;
        kif.i_KeyValid = 1'b0;
        chk1("zero_ready", kif.o_KeyReady, 1'b1);
        chk1("zero_busy", kif.o_Busy, 1'b0);
        chk1("zero_kv", kif.o_KeysValid, 1'b0);
        check_all("zero", 1'b1);
        tick();
        chk1("zero_no_accept_busy", kif.o_Busy, 1'b0);
        load_key(FIPS_KEY);
        wait_valid();
        read_rk(10, v);
        chk("zero_reload_rk10", v, FIPS_RK10);
`endif

        for (int t = 0; t < 6; t++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key_a);
            load_key(key_a);
            wait_valid();
            check_all($sformatf("rand%0d", t), 1'b0);
            read_rk(11 + int'($urandom_range(0, 4)), v);
            chk($sformatf("rand%0d_oor", t), v, 128'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
